// File: rtl/remote_mem_bridge.sv
// TileLink-UL slave that turns Get/Put requests into byte frames on a tx stream
// and assembles status/read-data responses from an rx stream.
`timescale 1ns/1ps
module remote_mem_bridge #(
  parameter int ADDR_WIDTH   = 64,
  parameter int DATA_WIDTH   = 64,
  parameter int SOURCE_WIDTH = 4,
  parameter int SIZE_WIDTH   = 3,
  parameter int TIMEOUT      = 65535
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [2:0]              a_opcode,
  input  logic [SIZE_WIDTH-1:0]   a_size,
  input  logic [SOURCE_WIDTH-1:0] a_source,
  input  logic [ADDR_WIDTH-1:0]   a_address,
  input  logic [DATA_WIDTH/8-1:0] a_mask,
  input  logic [DATA_WIDTH-1:0]   a_data,
  output logic                    d_valid,
  input  logic                    d_ready,
  output logic [2:0]              d_opcode,
  output logic [SIZE_WIDTH-1:0]   d_size,
  output logic [SOURCE_WIDTH-1:0] d_source,
  output logic [DATA_WIDTH-1:0]   d_data,
  output logic                    d_denied,
  output logic                    d_corrupt,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [7:0]              tx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  input  logic [7:0]              rx_data
);

  localparam int DB = DATA_WIDTH / 8;
  localparam int AB = ADDR_WIDTH / 8;
  localparam logic [7:0]  AB_LAST  = 8'(AB - 1);
  localparam logic [7:0]  DB_LAST  = 8'(DB - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [2:0]  OP_PUTF  = 3'd0;
  localparam logic [2:0]  OP_PUTP  = 3'd1;
  localparam logic [2:0]  OP_GET   = 3'd4;
  localparam logic [2:0]  D_ACK    = 3'd0;
  localparam logic [2:0]  D_ACKD   = 3'd1;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_MASK, S_WDATA, S_STATUS, S_RDATA, S_RESP
  } state_t;

  state_t                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [15:0]             tmo_q, tmo_d;
  logic                    a_ready_q, a_ready_d;
  logic                    rx_ready_q, rx_ready_d;
  logic                    tx_valid_q, tx_valid_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic                    d_valid_q, d_valid_d;
  logic [2:0]              d_opcode_q, d_opcode_d;
  logic [SIZE_WIDTH-1:0]   d_size_q, d_size_d;
  logic [SOURCE_WIDTH-1:0] d_source_q, d_source_d;
  logic [DATA_WIDTH-1:0]   d_data_q, d_data_d;
  logic                    d_denied_q, d_denied_d;
  logic                    d_corrupt_q, d_corrupt_d;

  logic [2:0]              op_q, op_d;
  logic [SIZE_WIDTH-1:0]   size_q, size_d;
  logic [SOURCE_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DB-1:0]           mask_q, mask_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

  logic tx_hs, rx_hs;
  logic resp_go, resp_err, is_get, is_wr;

  assign tx_hs = tx_valid_q & tx_ready;
  assign rx_hs = rx_valid & rx_ready_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmo_d       = '0;
    d_valid_d   = d_valid_q;
    d_opcode_d  = d_opcode_q;
    d_size_d    = d_size_q;
    d_source_d  = d_source_q;
    d_data_d    = d_data_q;
    d_denied_d  = d_denied_q;
    d_corrupt_d = d_corrupt_q;
    op_d        = op_q;
    size_d      = size_q;
    src_d       = src_q;
    addr_d      = addr_q;
    mask_d      = mask_q;
    wdata_d     = wdata_q;
    resp_go     = 1'b0;
    resp_err    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (a_valid && a_ready_q) begin
          op_d     = a_opcode;
          size_d   = a_size;
          src_d    = a_source;
          addr_d   = a_address;
          mask_d   = a_mask;
          wdata_d  = a_data;
          cnt_d    = '0;
          d_data_d = '0;
          if (a_opcode == OP_GET || a_opcode == OP_PUTF || a_opcode == OP_PUTP) begin
            state_d = S_CMD;
          end else begin
            resp_go  = 1'b1;
            resp_err = 1'b1;
          end
        end
      end
      S_CMD: begin
        if (tx_hs) begin
          state_d = S_ADDR;
          cnt_d   = '0;
        end
      end
      S_ADDR: begin
        if (tx_hs) begin
          if (cnt_q == AB_LAST) begin
            cnt_d   = '0;
            state_d = (op_q == OP_GET) ? S_STATUS : S_MASK;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_MASK: begin
        if (tx_hs) begin
          state_d = S_WDATA;
          cnt_d   = '0;
        end
      end
      S_WDATA: begin
        if (tx_hs) begin
          if (cnt_q == DB_LAST) begin
            cnt_d   = '0;
            state_d = S_STATUS;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_STATUS: begin
        if (rx_hs) begin
          if (rx_data != 8'h00) begin
            resp_go  = 1'b1;
            resp_err = 1'b1;
          end else if (op_q == OP_GET) begin
            state_d = S_RDATA;
            cnt_d   = '0;
          end else begin
            resp_go = 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          resp_go  = 1'b1;
          resp_err = 1'b1;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_RDATA: begin
        if (rx_hs) begin
          // Bytes arrive LSB first, so shifting right lands the first byte at bit 0.
          d_data_d = {rx_data, d_data_q[DATA_WIDTH-1:8]};
          if (cnt_q == DB_LAST) begin
            cnt_d   = '0;
            resp_go = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else if (tmo_q == TMO_LAST) begin
          resp_go  = 1'b1;
          resp_err = 1'b1;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_RESP: begin
        if (d_ready) begin
          state_d   = S_IDLE;
          d_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    is_get = (op_d == OP_GET);
    is_wr  = (op_d == OP_PUTF) || (op_d == OP_PUTP);

    if (resp_go) begin
      state_d     = S_RESP;
      d_valid_d   = 1'b1;
      d_opcode_d  = is_get ? D_ACKD : D_ACK;
      d_size_d    = size_d;
      d_source_d  = src_d;
      d_denied_d  = resp_err;
      d_corrupt_d = resp_err & is_get;
      if (resp_err) d_data_d = '0;
    end

    // Handshake outputs are registered, so they are derived from the next state.
    a_ready_d  = (state_d == S_IDLE);
    rx_ready_d = (state_d == S_IDLE) || (state_d == S_STATUS) || (state_d == S_RDATA);
    tx_valid_d = (state_d == S_CMD) || (state_d == S_ADDR) ||
                 (state_d == S_MASK) || (state_d == S_WDATA);
    tx_data_d  = 8'h00;
    case (state_d)
      S_CMD:  tx_data_d = {is_wr, 4'b0000, size_d[2:0]};
      S_ADDR: begin
        for (int i = 0; i < AB; i++)
          if (cnt_d == 8'(i)) tx_data_d = addr_d[8*i +: 8];
      end
      S_MASK: tx_data_d = 8'(mask_d);
      S_WDATA: begin
        for (int i = 0; i < DB; i++)
          if (cnt_d == 8'(i)) tx_data_d = wdata_d[8*i +: 8];
      end
      default: tx_data_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tmo_q       <= '0;
      a_ready_q   <= 1'b0;
      rx_ready_q  <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      d_valid_q   <= 1'b0;
      d_opcode_q  <= '0;
      d_size_q    <= '0;
      d_source_q  <= '0;
      d_data_q    <= '0;
      d_denied_q  <= 1'b0;
      d_corrupt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      a_ready_q   <= a_ready_d;
      rx_ready_q  <= rx_ready_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      d_valid_q   <= d_valid_d;
      d_opcode_q  <= d_opcode_d;
      d_size_q    <= d_size_d;
      d_source_q  <= d_source_d;
      d_data_q    <= d_data_d;
      d_denied_q  <= d_denied_d;
      d_corrupt_q <= d_corrupt_d;
    end
  end

  // Request fields are only meaningful after an accept, so they carry no reset.
  always_ff @(posedge clk) begin
    op_q    <= op_d;
    size_q  <= size_d;
    src_q   <= src_d;
    addr_q  <= addr_d;
    mask_q  <= mask_d;
    wdata_q <= wdata_d;
  end

  assign a_ready   = a_ready_q;
  assign rx_ready  = rx_ready_q;
  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign d_valid   = d_valid_q;
  assign d_opcode  = d_opcode_q;
  assign d_size    = d_size_q;
  assign d_source  = d_source_q;
  assign d_data    = d_data_q;
  assign d_denied  = d_denied_q;
  assign d_corrupt = d_corrupt_q;

endmodule

// File: tb/tb_remote_mem_bridge.sv
// Directed bench for remote_mem_bridge: vector table of full transactions plus
// hand-written timeout, stall and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_remote_mem_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [2:0]  a_opcode = '0;
  logic [2:0]  a_size = '0;
  logic [3:0]  a_source = '0;
  logic [63:0] a_address = '0;
  logic [7:0]  a_mask = '0;
  logic [63:0] a_data = '0;
  logic        d_valid;
  logic        d_ready = 1'b0;
  logic [2:0]  d_opcode;
  logic [2:0]  d_size;
  logic [3:0]  d_source;
  logic [63:0] d_data;
  logic        d_denied;
  logic        d_corrupt;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [7:0]  tx_data;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  rx_data = '0;

  always #5 clk = ~clk;

  remote_mem_bridge #(
    .ADDR_WIDTH(64), .DATA_WIDTH(64), .SOURCE_WIDTH(4), .SIZE_WIDTH(3), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
    .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
    .d_source(d_source), .d_data(d_data), .d_denied(d_denied), .d_corrupt(d_corrupt),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data)
  );

  typedef struct packed {
    logic [2:0]   op;
    logic [2:0]   size;
    logic [3:0]   src;
    logic [63:0]  addr;
    logic [7:0]   mask;
    logic [63:0]  data;
    logic [4:0]   rx_n;
    logic [4:0]   rx_used;
    logic [71:0]  rx;    // first byte in the most significant used position
    logic [4:0]   tx_n;
    logic [143:0] tx;    // first byte in the most significant used position
    logic [2:0]   dop;
    logic         den;
    logic         cor;
    logic [63:0]  dd;
  } vec_t;

  vec_t vecs[7];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [7:0] tx_log[1024];
  int tx_cnt = 0;
  logic [7:0] rx_buf[256];
  int rx_len = 0;
  int rx_idx = 0;
  bit tog = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (tx_valid && tx_ready) begin
      tx_log[tx_cnt] <= tx_data;
      tx_cnt <= tx_cnt + 1;
    end
    if (rx_valid && rx_ready) rx_idx <= rx_idx + 1;
  end

  always @(negedge clk) begin
    rx_valid = (rx_idx < rx_len);
    rx_data  = (rx_idx < rx_len) ? rx_buf[rx_idx] : 8'h00;
    tx_ready = tog ? ~tx_ready : 1'b1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 100 && rx_idx != rx_len; k++) @(negedge clk);
    chk("rx_drain_idle", 64'(rx_idx), 64'(rx_len));
  endtask

  task automatic accept(input int v, output int tx0);
    wait_drain();
    @(negedge clk);
    tx0       = tx_cnt;
    a_opcode  = vecs[v].op;
    a_size    = vecs[v].size;
    a_source  = vecs[v].src;
    a_address = vecs[v].addr;
    a_mask    = vecs[v].mask;
    a_data    = vecs[v].data;
    a_valid   = 1'b1;
    for (int k = 0; k < 50 && !a_ready; k++) @(negedge clk);
    chk($sformatf("v%0d_a_ready", v), 64'(a_ready), 64'd1);
    @(posedge clk);
    #1 a_valid = 1'b0;
  endtask

  task automatic wait_dvalid(input string nm);
    for (int k = 0; k < 400 && !d_valid; k++) @(negedge clk);
    chk(nm, 64'(d_valid), 64'd1);
  endtask

  task automatic d_ack();
    d_ready = 1'b1;
    @(posedge clk);
    #1 d_ready = 1'b0;
    @(negedge clk);
    chk("d_valid_fall", 64'(d_valid), 64'd0);
    chk("a_ready_back", 64'(a_ready), 64'd1);
  endtask

  task automatic run_txn(input int v, input int stall);
    vec_t t;
    int tx0, rx0, n;
    logic [143:0] txv;
    logic [71:0] rxv;
    t = vecs[v];
    txv = t.tx;
    rxv = t.rx;
    accept(v, tx0);
    rx0 = rx_idx;
    n = int'(t.rx_n);
    for (int i = 0; i < n; i++) rx_buf[rx_len + i] = rxv[(n-1-i)*8 +: 8];
    rx_len = rx_len + n;
    wait_dvalid($sformatf("v%0d_d_valid", v));
    chk($sformatf("v%0d_tx_count", v), 64'(tx_cnt - tx0), 64'(t.tx_n));
    n = int'(t.tx_n);
    for (int i = 0; i < n; i++)
      chk($sformatf("v%0d_tx_byte%0d", v, i), 64'(tx_log[tx0 + i]), 64'(txv[(n-1-i)*8 +: 8]));
    chk($sformatf("v%0d_rx_used", v), 64'(rx_idx - rx0), 64'(t.rx_used));
    chk($sformatf("v%0d_d_opcode", v), 64'(d_opcode), 64'(t.dop));
    chk($sformatf("v%0d_d_denied", v), 64'(d_denied), 64'(t.den));
    chk($sformatf("v%0d_d_corrupt", v), 64'(d_corrupt), 64'(t.cor));
    chk($sformatf("v%0d_d_data", v), d_data, t.dd);
    chk($sformatf("v%0d_d_size", v), 64'(d_size), 64'(t.size));
    chk($sformatf("v%0d_d_source", v), 64'(d_source), 64'(t.src));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_d_valid", 64'(d_valid), 64'd1);
      chk("stall_d_data", d_data, t.dd);
      chk("stall_d_opcode", 64'(d_opcode), 64'(t.dop));
      chk("stall_a_ready", 64'(a_ready), 64'd0);
    end
    d_ack();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int tx0, t0, t1;
    vecs[0] = '{op:3'd4, size:3'd3, src:4'd5, addr:64'h8000_1000, mask:8'hFF, data:64'h0,
                rx_n:5'd9, rx_used:5'd9, rx:72'h00_EF_BE_AD_DE_78_56_34_12,
                tx_n:5'd9, tx:144'h03_00_10_00_80_00_00_00_00,
                dop:3'd1, den:1'b0, cor:1'b0, dd:64'h12345678_DEADBEEF};
    vecs[1] = '{op:3'd0, size:3'd3, src:4'd2, addr:64'h10, mask:8'hFF, data:64'h01020304_05060708,
                rx_n:5'd1, rx_used:5'd1, rx:72'h00,
                tx_n:5'd18, tx:144'h83_10_00_00_00_00_00_00_00_FF_08_07_06_05_04_03_02_01,
                dop:3'd0, den:1'b0, cor:1'b0, dd:64'h0};
    vecs[2] = '{op:3'd4, size:3'd2, src:4'd7, addr:64'h1234, mask:8'h00, data:64'h0,
                rx_n:5'd2, rx_used:5'd1, rx:72'h01_AA,
                tx_n:5'd9, tx:144'h02_34_12_00_00_00_00_00_00,
                dop:3'd1, den:1'b1, cor:1'b1, dd:64'h0};
    vecs[3] = '{op:3'd1, size:3'd2, src:4'd3, addr:64'h20, mask:8'h0F, data:64'hAABBCCDD,
                rx_n:5'd1, rx_used:5'd1, rx:72'h00,
                tx_n:5'd18, tx:144'h82_20_00_00_00_00_00_00_00_0F_DD_CC_BB_AA_00_00_00_00,
                dop:3'd0, den:1'b0, cor:1'b0, dd:64'h0};
    vecs[4] = '{op:3'd0, size:3'd3, src:4'd9, addr:64'h8, mask:8'hFF, data:64'h11223344_55667788,
                rx_n:5'd1, rx_used:5'd1, rx:72'h05,
                tx_n:5'd18, tx:144'h83_08_00_00_00_00_00_00_00_FF_88_77_66_55_44_33_22_11,
                dop:3'd0, den:1'b1, cor:1'b0, dd:64'h0};
    vecs[5] = '{op:3'd2, size:3'd3, src:4'd4, addr:64'h40, mask:8'hFF, data:64'h0,
                rx_n:5'd0, rx_used:5'd0, rx:72'h0,
                tx_n:5'd0, tx:144'h0,
                dop:3'd0, den:1'b1, cor:1'b0, dd:64'h0};
    vecs[6] = '{op:3'd4, size:3'd3, src:4'hF, addr:64'hFFFF_FFFF_FFFF_FFF8, mask:8'hFF, data:64'h0,
                rx_n:5'd9, rx_used:5'd9, rx:72'h00_01_02_03_04_05_06_07_08,
                tx_n:5'd9, tx:144'h03_F8_FF_FF_FF_FF_FF_FF_FF,
                dop:3'd1, den:1'b0, cor:1'b0, dd:64'h08070605_04030201};

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 64'({a_ready, d_valid, d_opcode, d_size, d_source, d_denied, d_corrupt,
                          tx_valid, tx_data, rx_ready}), 64'd0);
    chk("rst_d_data", d_data, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_a_ready", 64'(a_ready), 64'd1);
    chk("idle_rx_ready", 64'(rx_ready), 64'd1);

    for (int v = 0; v < 7; v++) run_txn(v, 0);

    // tx back-pressure toggling every cycle plus a held-off D channel.
    tog = 1'b1;
    run_txn(0, 5);
    tog = 1'b0;

    // Response timeout with no rx bytes, then stale bytes drained in IDLE.
    accept(0, tx0);
    for (int k = 0; k < 200 && tx_cnt != tx0 + 9; k++) @(negedge clk);
    t0 = cyc;
    chk("tmo_tx_count", 64'(tx_cnt - tx0), 64'd9);
    chk("tmo_rx_ready", 64'(rx_ready), 64'd1);
    for (int k = 0; k < 200 && !d_valid; k++) @(negedge clk);
    t1 = cyc;
    chk("tmo_d_valid", 64'(d_valid), 64'd1);
    chk("tmo_latency", 64'(t1 - t0), 64'd16);
    chk("tmo_d_denied", 64'(d_denied), 64'd1);
    chk("tmo_d_corrupt", 64'(d_corrupt), 64'd1);
    chk("tmo_d_opcode", 64'(d_opcode), 64'd1);
    chk("tmo_d_data", d_data, 64'd0);
    d_ack();
    rx_buf[rx_len] = 8'h00;
    rx_buf[rx_len + 1] = 8'h11;
    rx_buf[rx_len + 2] = 8'h22;
    rx_len = rx_len + 3;
    run_txn(0, 0);

    // Reset pulsed while address bytes are going out.
    accept(6, tx0);
    for (int k = 0; k < 50 && tx_cnt < tx0 + 3; k++) @(negedge clk);
    chk("mid_tx_valid", 64'(tx_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", 64'({a_ready, d_valid, d_opcode, d_size, d_source, d_denied, d_corrupt,
                             tx_valid, tx_data, rx_ready}), 64'd0);
    chk("midrst_d_data", d_data, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_a_ready", 64'(a_ready), 64'd1);
    chk("postrst_d_valid", 64'(d_valid), 64'd0);
    chk("postrst_tx_valid", 64'(tx_valid), 64'd0);
    run_txn(1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
